// File: rtl/mac1_dot16.sv
// Two-stage pipelined 16-element dot product: registered lane products, then a registered adder tree.
// Define MAC1_SIGNED_EN for two's-complement elements and a signed result (default build is unsigned).
module mac1_dot16 #(
  parameter int N_ELEM = 16,
  parameter int EW     = 8,
  parameter int SW     = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [EW*N_ELEM-1:0]  p,
  input  logic [EW*N_ELEM-1:0]  w,
  output logic                  out_valid,
  output logic [SW-1:0]         s
);

  localparam int PW = 2 * EW;

`ifdef MAC1_SIGNED_EN
  localparam logic SGN = 1'b1;
`else
  localparam logic SGN = 1'b0;
`endif

  logic [PW-1:0]   prod_c [N_ELEM];
  logic [PW-1:0]   prod_q [N_ELEM];
  logic            v1;

  logic [PW:0]     l1 [8];
  logic [PW+1:0]   l2 [4];
  logic [PW+2:0]   l3 [2];
  logic [SW-1:0]   sum_c;

  // Operands are widened to the product width first; the signedness of pe/we
  // decides whether that widening sign- or zero-extends.
  always_comb begin
`ifdef MAC1_SIGNED_EN
    logic signed [EW-1:0] pe;
    logic signed [EW-1:0] we;
`else
    logic [EW-1:0] pe;
    logic [EW-1:0] we;
`endif
    pe = '0;
    we = '0;
    for (int unsigned i = 0; i < N_ELEM; i++) begin
      pe        = p[EW*i +: EW];
      we        = w[EW*i +: EW];
      prod_c[i] = (PW)'(pe) * (PW)'(we);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ELEM; i++) prod_q[i] <= '0;
      v1 <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_ELEM; i++) prod_q[i] <= prod_c[i];
      v1 <= in_valid;
    end
  end

  // Each tree level grows by one bit; the top bit is extended with the sign only in the signed build.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++)
      l1[i] = {SGN & prod_q[2*i][PW-1], prod_q[2*i]}
            + {SGN & prod_q[2*i+1][PW-1], prod_q[2*i+1]};
    for (int unsigned i = 0; i < 4; i++)
      l2[i] = {SGN & l1[2*i][PW], l1[2*i]} + {SGN & l1[2*i+1][PW], l1[2*i+1]};
    for (int unsigned i = 0; i < 2; i++)
      l3[i] = {SGN & l2[2*i][PW+1], l2[2*i]} + {SGN & l2[2*i+1][PW+1], l2[2*i+1]};
    sum_c = {SGN & l3[0][PW+2], l3[0]} + {SGN & l3[1][PW+2], l3[1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      out_valid <= 1'b0;
    end else begin
      s         <= sum_c;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_mac1_dot16.sv
// Self-checking bench for mac1_dot16: directed vector table, random stream and reset corner cases.
// Expected values follow the MAC1_SIGNED_EN setting the bench is compiled with.
module tb_mac1_dot16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] p;
  logic [127:0] w;
  logic         out_valid;
  logic [19:0]  s;

  int checks;
  int failures;

  typedef struct {
    logic [127:0] p;
    logic [127:0] w;
    logic [19:0]  exp;
  } vec_t;

  localparam int NV = 10;
  localparam int NR = 40;

  vec_t         tbl [NV];
  logic [127:0] rp  [NR];
  logic [127:0] rw  [NR];
  logic [19:0]  rexp[NR];

  mac1_dot16 #(.N_ELEM(16), .EW(8), .SW(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .p         (p),
    .w         (w),
    .out_valid (out_valid),
    .s         (s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] pv, input logic [127:0] wv);
    in_valid = v;
    p        = pv;
    w        = wv;
  endtask

  function automatic logic [19:0] dot(input logic [127:0] pv, input logic [127:0] wv);
    int acc;
    logic [7:0] a;
    logic [7:0] b;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      a = pv[8*i +: 8];
      b = wv[8*i +: 8];
`ifdef MAC1_SIGNED_EN
      acc += int'($signed(a)) * int'($signed(b));
`else
      acc += int'(a) * int'(b);
`endif
    end
    return acc[19:0];
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0] = '{128'h0, 128'h0, 20'h00000};
    tbl[2] = '{128'h05 << 24, 128'h07 << 24, 20'h00023};
    tbl[3] = '{128'hFF, 128'hFF << 8, 20'h00000};
    tbl[4] = '{{16{8'h01}}, {16{8'h01}}, 20'h00010};
    tbl[6] = '{128'h0F0E0D0C0B0A09080706050403020100, {16{8'h01}}, 20'h00078};
    tbl[7] = '{{16{8'h02}}, 128'h0F0E0D0C0B0A09080706050403020100, 20'h000F0};
`ifdef MAC1_SIGNED_EN
    tbl[1] = '{{16{8'hFF}}, {16{8'hFF}}, 20'h00010};
    tbl[5] = '{128'hFF << 120, 128'h02 << 120, 20'hFFFFE};
    tbl[8] = '{{16{8'h80}}, {16{8'h7F}}, 20'hC0800};
    tbl[9] = '{{16{8'h80}}, {16{8'h80}}, 20'h40000};
`else
    tbl[1] = '{{16{8'hFF}}, {16{8'hFF}}, 20'hFE010};
    tbl[5] = '{128'hFF << 120, 128'h02 << 120, 20'h001FE};
    tbl[8] = '{{16{8'h80}}, {16{8'h7F}}, 20'h3F800};
    tbl[9] = '{{16{8'h80}}, {16{8'h80}}, 20'h40000};
`endif

    // reset with non-zero inputs so a cleared output is meaningful
    rst = 1'b1;
    drive(1'b1, '1, '1);
    repeat (3) @(negedge clk);
    check("rst_valid", 20'(out_valid), 20'h0);
    check("rst_s", s, 20'h0);
    rst = 1'b0;
    drive(1'b1, '0, '0);
    @(negedge clk);
    check("lat1_valid", 20'(out_valid), 20'h0);
    drive(1'b0, '0, '0);
    @(negedge clk);
    check("lat2_valid", 20'(out_valid), 20'h1);
    check("lat2_s", s, 20'h0);

    // directed table streamed back-to-back
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("tbl%0d_valid", i - 2), 20'(out_valid), 20'h1);
        check($sformatf("tbl%0d_s", i - 2), s, tbl[i-2].exp);
      end
      if (i < NV) drive(1'b1, tbl[i].p, tbl[i].w);
      else        drive(1'b0, '0, '0);
    end

    for (int i = 0; i < NR; i++) begin
      rp[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rw[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rexp[i] = dot(rp[i], rw[i]);
    end

    // random back-to-back stream
    for (int i = 0; i < NR + 3; i++) begin
      @(negedge clk);
      if (i >= 2 && i < NR + 2) begin
        check($sformatf("rnd%0d_valid", i - 2), 20'(out_valid), 20'h1);
        check($sformatf("rnd%0d_s", i - 2), s, rexp[i-2]);
      end else begin
        check($sformatf("rnd_idle%0d_valid", i), 20'(out_valid), 20'h0);
      end
      if (i < NR) drive(1'b1, rp[i], rw[i]);
      else        drive(1'b0, '0, '0);
    end

    // reset while two valid pairs are in flight
    @(negedge clk);
    drive(1'b1, '1, '1);
    @(negedge clk);
    drive(1'b1, {16{8'h01}}, {16{8'h01}});
    @(negedge clk);
    drive(1'b0, '0, '0);
    @(posedge clk);
    #1;
    check("abort_pre_valid", 20'(out_valid), 20'h1);
    #1 rst = 1'b1;
    #1;
    check("abort_async_valid", 20'(out_valid), 20'h0);
    check("abort_async_s", s, 20'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_post%0d_valid", i), 20'(out_valid), 20'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
